// File: rtl/word_array_ctrl_if.sv
// Request/response and debug-peek bundle for word_array_ctrl.
interface word_array_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
);
   logic              sel;
   logic [1:0]        op;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  in_bus;
   logic [WIDTH-1:0]  out_bus;
   logic              out_valid;
   logic              err;
   logic              busy;
   logic [ADDR_W-1:0] dbg_addr;
   logic [WIDTH-1:0]  dbg_data;

   modport master (
      output sel, op, req_valid, addr, in_bus, dbg_addr,
      input  req_ready, out_bus, out_valid, err, busy, dbg_data
   );

   modport slave (
      input  sel, op, req_valid, addr, in_bus, dbg_addr,
      output req_ready, out_bus, out_valid, err, busy, dbg_data
   );
endinterface

// File: rtl/word_array_ctrl.sv
// Word array controller: DEPTH x WIDTH storage with handshaked read/write,
// a sequenced clear-all, registered read data and a combinational peek port.
//
// state | meaning
// IDLE  | accepting requests (req_ready=1)
// CLEAR | zeroing one word per cycle, requests stalled (busy=1)
module word_array_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input logic        clk,
   input logic        rst,
   word_array_if.slave bus
);
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic              accept;
   logic              addr_ok;
   logic              dbg_ok;

   assign bus.req_ready = (state == IDLE) & ~rst;
   assign bus.busy      = (state == CLEAR);
   assign accept        = bus.req_valid & bus.sel & (state == IDLE);
   assign addr_ok       = {1'b0, bus.addr} < DEPTH_L;
   assign dbg_ok        = {1'b0, bus.dbg_addr} < DEPTH_L;
   assign bus.dbg_data  = dbg_ok ? mem[bus.dbg_addr] : '0;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: clear-all runs until the last word has been zeroed
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept && bus.op == OP_CLEAR) state_nxt = CLEAR;
         CLEAR: if (clr_cnt == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Clear sweep counter, parked at zero outside CLEAR
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                clr_cnt <= '0;
      else if (state == CLEAR && clr_cnt != LAST) clr_cnt <= clr_cnt + 1'b1;
      else                                    clr_cnt <= '0;
   end

   // Storage: clear sweep or accepted in-range write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state == CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (accept && bus.op == OP_WRITE && addr_ok) begin
         mem[bus.addr] <= bus.in_bus;
      end
   end

   // Read data register and single-cycle valid/error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_bus   <= '0;
         bus.out_valid <= 1'b0;
         bus.err       <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         bus.err       <= 1'b0;
         if (accept && bus.op == OP_READ) begin
            bus.out_valid <= 1'b1;
            if (addr_ok) begin
               bus.out_bus <= mem[bus.addr];
            end else begin
               bus.out_bus <= '0;
               bus.err     <= 1'b1;
            end
         end else if (accept && bus.op == OP_WRITE && !addr_ok) begin
            bus.err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_word_array_ctrl.sv
// Bench for word_array_ctrl: directed steps plus randomized traffic against
// an array model, on a DEPTH=16 instance (a) and a DEPTH=12 instance (b).
module tb_word_array_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   logic [7:0] m16 [16];
   logic [7:0] last_rd;
   int         cnt;

   word_array_if #(.WIDTH(8), .ADDR_W(4)) a ();
   word_array_if #(.WIDTH(8), .ADDR_W(4)) b ();

   word_array_ctrl #(.WIDTH(8), .DEPTH(16)) dut16 (.clk(clk), .rst(rst), .bus(a));
   word_array_ctrl #(.WIDTH(8), .DEPTH(12)) dut12 (.clk(clk), .rst(rst), .bus(b));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request on a, wait (bounded) for ready, return #1 after accept edge.
   task automatic req_a(input logic [1:0] op, input logic [3:0] ad, input logic [7:0] d);
      int i;
      a.sel = 1'b1; a.op = op; a.addr = ad; a.in_bus = d; a.req_valid = 1'b1;
      i = 0;
      while (a.req_ready !== 1'b1 && i < 200) begin step(); i++; end
      if (a.req_ready !== 1'b1) chk("ready_timeout", 0, 1);
      step();
      case (op)
         2'b00: last_rd = m16[ad];
         2'b01: m16[ad] = d;
         2'b10: for (int k = 0; k < 16; k++) m16[k] = 8'h00;
         default: ;
      endcase
   endtask

   task automatic idle_a();
      a.req_valid = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      a.sel = 0; a.op = 2'b11; a.req_valid = 0; a.addr = 0; a.in_bus = 0; a.dbg_addr = 0;
      b.sel = 0; b.op = 2'b11; b.req_valid = 0; b.addr = 0; b.in_bus = 0; b.dbg_addr = 0;
      for (int k = 0; k < 16; k++) m16[k] = 8'h00;
      last_rd = 8'h00;
      #12;
      chk("rst_out_bus", a.out_bus, 0);
      chk("rst_out_valid", a.out_valid, 0);
      chk("rst_err", a.err, 0);
      chk("rst_busy", a.busy, 0);
      @(negedge clk); rst = 1'b0;
      step();
      chk("rst_ready", a.req_ready, 1);

      // Write 0x55 to 3, peek, read back
      a.dbg_addr = 4'd3;
      req_a(2'b01, 4'd3, 8'h55);
      chk("wr_dbg3", a.dbg_data, 8'h55);
      chk("wr_no_valid", a.out_valid, 0);
      chk("wr_no_err", a.err, 0);
      req_a(2'b00, 4'd3, 8'h00);
      chk("rd3_data", a.out_bus, 8'h55);
      chk("rd3_valid", a.out_valid, 1);
      idle_a();
      chk("rd3_pulse_end", a.out_valid, 0);
      chk("rd3_hold", a.out_bus, 8'h55);

      // sel=0 write attempt for 3 cycles
      a.sel = 0; a.op = 2'b01; a.addr = 4'd5; a.in_bus = 8'hAA; a.req_valid = 1; a.dbg_addr = 4'd5;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("nosel_err", a.err, 0);
         chk("nosel_valid", a.out_valid, 0);
         chk("nosel_ready", a.req_ready, 1);
      end
      chk("nosel_dbg5", a.dbg_data, 8'h00);
      a.req_valid = 0;

      // Randomized read/write/no-op traffic against the model
      for (int n = 0; n < 300; n++) begin
         logic [1:0] op;
         logic [3:0] ad;
         op = 2'($urandom_range(0, 2));
         if (op == 2'b10) op = 2'b11;
         ad = 4'($urandom);
         req_a(op, ad, 8'($urandom));
         chk("rnd_valid", a.out_valid, (op == 2'b00) ? 1 : 0);
         chk("rnd_out_bus", a.out_bus, last_rd);
         chk("rnd_err", a.err, 0);
         a.dbg_addr = 4'($urandom);
         #1 chk("rnd_dbg", a.dbg_data, m16[a.dbg_addr]);
         if ($urandom_range(0, 3) == 0) idle_a();
      end
      idle_a();

      // Back-to-back reads
      req_a(2'b01, 4'd0, 8'h11);
      req_a(2'b01, 4'd1, 8'h22);
      req_a(2'b01, 4'd2, 8'h33);
      req_a(2'b00, 4'd0, 8'h00);
      chk("b2b_0", a.out_bus, 8'h11); chk("b2b_v0", a.out_valid, 1);
      req_a(2'b00, 4'd1, 8'h00);
      chk("b2b_1", a.out_bus, 8'h22); chk("b2b_v1", a.out_valid, 1);
      req_a(2'b00, 4'd2, 8'h00);
      chk("b2b_2", a.out_bus, 8'h33); chk("b2b_v2", a.out_valid, 1);
      idle_a();
      chk("b2b_end", a.out_valid, 0);

      // Fill, clear-all with a pending read
      for (int k = 0; k < 16; k++) req_a(2'b01, 4'(k), 8'hF0 + 8'(k));
      req_a(2'b10, 4'd0, 8'h00);
      a.op = 2'b00; a.addr = 4'd4; a.dbg_addr = 4'd10;
      cnt = 0;
      while (a.busy === 1'b1 && cnt < 100) begin
         if (a.req_ready !== 1'b0) chk("clr_ready_low", a.req_ready, 0);
         if (cnt == 8) begin
            chk("clr_partial_hi", a.dbg_data, 8'hFA);
            a.dbg_addr = 4'd3;
            #1 chk("clr_partial_lo", a.dbg_data, 8'h00);
         end
         cnt++;
         step();
      end
      chk("clr_busy_cycles", cnt, 16);
      chk("clr_ready_back", a.req_ready, 1);
      chk("clr_no_valid", a.out_valid, 0);
      step();
      chk("clr_rd_valid", a.out_valid, 1);
      chk("clr_rd_data", a.out_bus, 8'h00);
      last_rd = 8'h00;
      idle_a();

      // Reset in the middle of a clear sweep
      for (int k = 0; k < 16; k++) req_a(2'b01, 4'(k), 8'hFF);
      req_a(2'b00, 4'd9, 8'h00);
      chk("pre_rst_rd", a.out_bus, 8'hFF);
      req_a(2'b10, 4'd0, 8'h00);
      a.req_valid = 0;
      for (int k = 0; k < 6; k++) step();
      a.dbg_addr = 4'd12;
      #2 chk("pre_rst_dbg12", a.dbg_data, 8'hFF);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", a.busy, 0);
      chk("mid_rst_out_bus", a.out_bus, 0);
      for (int k = 0; k < 16; k++) begin
         a.dbg_addr = 4'(k);
         #0.1 chk("mid_rst_word", a.dbg_data, 0);
      end
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 16; k++) m16[k] = 8'h00;
      step();
      chk("post_rst_ready", a.req_ready, 1);
      chk("post_rst_busy", a.busy, 0);
      for (int k = 0; k < 16; k++) begin
         req_a(2'b00, 4'(k), 8'h00);
         chk("post_rst_word", a.out_bus, 8'h00);
      end
      idle_a();

      // DEPTH=12: out-of-range write and read
      b.sel = 1; b.req_valid = 1; b.op = 2'b01; b.addr = 4'd11; b.in_bus = 8'h5A;
      step();
      chk("d12_wr11_err", b.err, 0);
      b.addr = 4'd13; b.in_bus = 8'h77;
      step();
      chk("d12_wr13_err", b.err, 1);
      chk("d12_wr13_valid", b.out_valid, 0);
      b.op = 2'b00; b.addr = 4'd11;
      step();
      chk("d12_wr13_err_pulse", b.err, 0);
      chk("d12_rd11", b.out_bus, 8'h5A);
      b.addr = 4'd13;
      step();
      chk("d12_rd13_data", b.out_bus, 8'h00);
      chk("d12_rd13_valid", b.out_valid, 1);
      chk("d12_rd13_err", b.err, 1);
      b.req_valid = 0; b.dbg_addr = 4'd13;
      step();
      chk("d12_err_end", b.err, 0);
      chk("d12_dbg13", b.dbg_data, 8'h00);
      b.dbg_addr = 4'd11;
      #1 chk("d12_dbg11", b.dbg_data, 8'h5A);
      for (int k = 0; k < 11; k++) begin
         b.dbg_addr = 4'(k);
         #0.1 chk("d12_untouched", b.dbg_data, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/word_array_ctrl.md
Name: word_array_ctrl

Overview:
- Clocked, parametrised successor to the single 8-bit word cell: an array of DEPTH words of WIDTH bits.
- Supports selected read, write and a sequenced clear-all operation.
- Requests use a valid/ready handshake; reads return registered data with a one-cycle valid pulse.
- Sits between the bus master and storage. Exposes a combinational debug peek port, the successor of the single-word stored_value output.

Parameters:
- WIDTH, 8, bits per word.
- DEPTH, 16, number of words; need not be a power of two; minimum 2.
- ADDR_W, $clog2(DEPTH), address width. Derived localparam; not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sel  input  1  array select; request ignored when 0.
- op  input  2  operation code: 00 read, 01 write, 10 clear-all, 11 no-op.
- req_valid  input  1  request present.
- req_ready  output  1  array can accept a request this cycle.
- addr  input  ADDR_W  word address for read/write.
- in_bus  input  WIDTH  write data.
- out_bus  output  WIDTH  registered read data; holds until the next accepted read.
- out_valid  output  1  one-cycle pulse, read data valid.
- err  output  1  one-cycle pulse, out-of-range read or write.
- busy  output  1  clear-all sequence in progress.
- dbg_addr  input  ADDR_W  peek address.
- dbg_data  output  WIDTH  combinational contents of word dbg_addr.

Behaviour:
- Reset (async assert, any state):
  - All words 0; out_bus=0, out_valid=0, err=0, busy=0.
  - State IDLE, clear counter 0; req_ready=1 once rst deasserts.
- Accept: req_valid & sel & req_ready at a rising edge. No other cycle changes memory except a CLEAR step.
- States IDLE and CLEAR; req_ready = (state==IDLE).
- Read (op=00), accepted at edge N:
  - addr < DEPTH: out_bus <= mem[addr] at edge N, so out_valid=1 during cycle N..N+1. Latency 1.
  - addr >= DEPTH: out_bus <= 0, out_valid=1, err=1 for one cycle.
- Write (op=01): mem[addr] <= in_bus at the accept edge.
  - addr >= DEPTH: no write, err=1 for one cycle, out_bus unchanged.
  - out_valid stays 0.
- Read in the cycle immediately after a write to the same address returns the new data.
- out_bus and out_valid are unchanged by writes, no-ops and clears, except that out_valid deasserts after its single pulse.
- Clear-all (op=10) accepted:
  - IDLE -> CLEAR, counter=0, busy=1, req_ready=0.
  - Each CLEAR cycle: mem[counter] <= 0, counter++.
  - On clearing word DEPTH-1: -> IDLE, busy=0 next cycle.
  - busy is high for exactly DEPTH cycles; req_ready returns 1 the cycle after.
- Requests during CLEAR are not accepted and have no effect; the master holds req_valid until req_ready.
- No-op (op=11) accepted: no state change, no pulses.
- sel=0 with req_valid=1: not accepted, no effect. req_ready still reflects state.
- dbg_data = mem[dbg_addr], purely combinational; 0 if dbg_addr >= DEPTH. During CLEAR it shows partially cleared contents.
- Reset mid-CLEAR: aborts immediately; all words 0, state IDLE.
- The err and out_valid pulses never extend beyond one cycle, even with back-to-back accepted reads. Back-to-back reads give one pulse per read, i.e. out_valid is high continuously.

Test Plan:
- Reset, then write 0x55 to addr 3 and read addr 3 -> out_bus=0x55 one cycle after read accept, out_valid high exactly 1 cycle; dbg_addr=3 gives dbg_data=0x55 right after the write edge.
- sel=0, op=01, addr=5, in_bus=0xAA, req_valid=1 for 3 cycles -> mem[5] stays 0x00 via dbg; no err, no out_valid.
- Fill all 16 words with 0xF0+i, issue clear-all:
  - busy=1 and req_ready=0 for exactly 16 cycles.
  - A read held pending during CLEAR is accepted only after busy drops and returns 0x00.
- DEPTH=12 instance: write 0x77 to addr 13 -> err pulse, no memory change; read addr 13 -> out_bus=0x00, out_valid=1, err=1.
- Back-to-back reads of addr 0 (0x11), 1 (0x22), 2 (0x33) on consecutive cycles -> out_bus 0x11, 0x22, 0x33 on successive cycles, out_valid high 3 cycles.
- Assert rst asynchronously mid-cycle during CLEAR at counter=6 after prefill 0xFF -> outputs zero immediately; after deassert req_ready=1, busy=0, every word reads 0x00.
